sm_selfopt_governor: RTL and testbench

Multi-channel, epoch-based self-optimising governor for a cluster of SMs, and the successor to the single-SM EWMA/hysteresis controller. For each of NUM_CH SMs it filters a sampled performance counter and votes DVFS level changes once per epoch. Every change goes through a per-channel req/ack handshake with the clock/voltage sequencer. A shared power budget gates up-steps and forces step-downs. A per-channel warp cap follows the committed level and is cut when throttling.

---
 rtl/sm_selfopt_governor.sv | 204 ++++++++++++++++++++
 tb/tb_sm_selfopt_governor.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/sm_selfopt_governor.sv
`default_nettype none
// ============================================================================
// Module   : sm_selfopt_governor
// Brief    : Per-SM EWMA filter, epoch voting and power-budgeted DVFS requests
//            with req/ack handshake and per-channel warp caps.
// Revision : 1.0
// ============================================================================
module sm_selfopt_governor #(
    parameter int NUM_CH        = 4,
    parameter int CNT_W         = 16,
    parameter int EWMA_SHIFT    = 4,
    parameter int LVL_W         = 2,
    parameter int EPOCH_CYC     = 64,
    parameter int VOTE_N        = 3,
    parameter int TARGET        = 1000,
    parameter int HYST_UP       = 3,
    parameter int HYST_DOWN     = 1,
    parameter int POWER_PER_LVL = 50,
    parameter int WARP_BASE     = 16,
    parameter int WARP_STEP     = 16,
    parameter int WARP_MAX      = 64,
    parameter int WARP_MIN      = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [NUM_CH*CNT_W-1:0] perf_cnt,
    input  logic [NUM_CH-1:0]       perf_vld,
    input  logic [15:0]             power_budget,
    output logic [NUM_CH-1:0]       dvfs_req_vld,
    output logic [NUM_CH*LVL_W-1:0] dvfs_req_lvl,
    input  logic [NUM_CH-1:0]       dvfs_ack,
    output logic [NUM_CH*LVL_W-1:0] dvfs_lvl,
    output logic [NUM_CH*8-1:0]     warp_cap,
    output logic                    throttle
);

    localparam int                    c_EPOCH_W    = (EPOCH_CYC > 1) ? $clog2(EPOCH_CYC) : 1;
    localparam int                    c_VOTE_W     = $clog2(VOTE_N + 1);
    localparam logic [c_EPOCH_W-1:0]  c_EPOCH_LAST = c_EPOCH_W'(EPOCH_CYC - 1);
    localparam logic [c_VOTE_W-1:0]   c_VOTE_FULL  = c_VOTE_W'(VOTE_N);
    localparam logic [LVL_W-1:0]      c_LVL_MAX    = '1;
    localparam logic [CNT_W-1:0]      c_UP_THR     = CNT_W'(TARGET + HYST_UP);
    localparam logic [CNT_W-1:0]      c_DN_THR     = CNT_W'(TARGET - HYST_DOWN);
    localparam logic [16:0]           c_PWR_STEP   = 17'(POWER_PER_LVL);

    logic [CNT_W-1:0]     r_ewma_q    [NUM_CH];
    logic [CNT_W-1:0]     w_ewma_d    [NUM_CH];
    logic [c_VOTE_W-1:0]  r_up_q      [NUM_CH];
    logic [c_VOTE_W-1:0]  w_up_d      [NUM_CH];
    logic [c_VOTE_W-1:0]  r_dn_q      [NUM_CH];
    logic [c_VOTE_W-1:0]  w_dn_d      [NUM_CH];
    logic [c_VOTE_W-1:0]  w_up_vote   [NUM_CH];
    logic [c_VOTE_W-1:0]  w_dn_vote   [NUM_CH];
    logic [LVL_W-1:0]     r_lvl_q     [NUM_CH];
    logic [LVL_W-1:0]     w_lvl_d     [NUM_CH];
    logic [LVL_W-1:0]     r_req_lvl_q [NUM_CH];
    logic [LVL_W-1:0]     w_req_lvl_d [NUM_CH];
    logic [7:0]           r_warp_q    [NUM_CH];
    logic [7:0]           w_warp_d    [NUM_CH];
    logic [NUM_CH-1:0]    r_req_vld_q, w_req_vld_d;
    logic [c_EPOCH_W-1:0] r_cnt_q, w_cnt_d;
    logic                 r_throttle_q, w_throttle_d;

    logic                 w_tick, w_over, w_up_room, w_frc_found, w_up_found;
    logic [15:0]          w_lvl_sum, w_power_used, w_cap;
    logic [LVL_W-1:0]     w_frc_lvl;
    logic [NUM_CH-1:0]    w_frc_sel, w_dn_sel, w_up_sel;

    always_comb begin
        w_tick = enable && (r_cnt_q == c_EPOCH_LAST);
        if (!enable || (r_cnt_q == c_EPOCH_LAST)) w_cnt_d = '0;
        else                                     w_cnt_d = r_cnt_q + c_EPOCH_W'(1);
        // A pending channel is charged at the level it is moving to
        w_lvl_sum = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_lvl_sum = w_lvl_sum + 16'(r_req_vld_q[i] ? r_req_lvl_q[i] : r_lvl_q[i]) + 16'd1;
        end
        w_power_used = w_lvl_sum * 16'(POWER_PER_LVL);
        w_over       = w_power_used > power_budget;
        w_up_room    = ({1'b0, w_power_used} + c_PWR_STEP) <= {1'b0, power_budget};
        w_throttle_d = w_tick ? w_over : r_throttle_q;
    end

    always_comb begin
        w_frc_sel   = '0;
        w_frc_found = 1'b0;
        w_frc_lvl   = '0;
        w_dn_sel    = '0;
        w_up_sel    = '0;
        w_up_found  = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_up_vote[i] = r_up_q[i];
            w_dn_vote[i] = r_dn_q[i];
            if (w_tick) begin
                if (r_req_vld_q[i]) begin
                    w_up_vote[i] = '0;
                    w_dn_vote[i] = '0;
                end else begin
                    w_up_vote[i] = (r_ewma_q[i] > c_UP_THR) ?
                                   ((r_up_q[i] == c_VOTE_FULL) ? r_up_q[i] : r_up_q[i] + c_VOTE_W'(1)) : '0;
                    w_dn_vote[i] = (r_ewma_q[i] < c_DN_THR) ?
                                   ((r_dn_q[i] == c_VOTE_FULL) ? r_dn_q[i] : r_dn_q[i] + c_VOTE_W'(1)) : '0;
                end
            end
            // Strict '>' keeps the lowest index among equal-level candidates
            if (w_tick && w_over && !r_req_vld_q[i] && (r_lvl_q[i] != '0) &&
                (!w_frc_found || (r_lvl_q[i] > w_frc_lvl))) begin
                w_frc_sel    = '0;
                w_frc_sel[i] = 1'b1;
                w_frc_found  = 1'b1;
                w_frc_lvl    = r_lvl_q[i];
            end
            if (w_tick && !r_req_vld_q[i] && (w_dn_vote[i] == c_VOTE_FULL) && (r_lvl_q[i] != '0))
                w_dn_sel[i] = 1'b1;
            if (w_tick && !w_over && w_up_room && !w_up_found && !r_req_vld_q[i] &&
                (w_up_vote[i] == c_VOTE_FULL) && (r_lvl_q[i] != c_LVL_MAX)) begin
                w_up_sel[i] = 1'b1;
                w_up_found  = 1'b1;
            end
        end
    end

    always_comb begin
        w_cap       = '0;
        w_req_vld_d = r_req_vld_q;
        for (int i = 0; i < NUM_CH; i++) begin
            w_ewma_d[i] = r_ewma_q[i];
            if (perf_vld[i])
                w_ewma_d[i] = r_ewma_q[i] - (r_ewma_q[i] >> EWMA_SHIFT)
                            + (perf_cnt[i*CNT_W +: CNT_W] >> EWMA_SHIFT);
            w_up_d[i]      = w_up_vote[i];
            w_dn_d[i]      = w_dn_vote[i];
            w_lvl_d[i]     = r_lvl_q[i];
            w_req_lvl_d[i] = r_req_lvl_q[i];
            if (r_req_vld_q[i]) begin
                if (dvfs_ack[i]) begin
                    w_req_vld_d[i] = 1'b0;
                    w_lvl_d[i]     = r_req_lvl_q[i];
                end
            end else if (w_frc_sel[i] || w_dn_sel[i]) begin
                w_req_vld_d[i] = 1'b1;
                w_req_lvl_d[i] = r_lvl_q[i] - LVL_W'(1);
                w_up_d[i]      = '0;
                w_dn_d[i]      = '0;
            end else if (w_up_sel[i]) begin
                w_req_vld_d[i] = 1'b1;
                w_req_lvl_d[i] = r_lvl_q[i] + LVL_W'(1);
                w_up_d[i]      = '0;
                w_dn_d[i]      = '0;
            end else begin
                w_req_lvl_d[i] = r_lvl_q[i];
            end
            w_cap = 16'(WARP_BASE) + 16'(r_lvl_q[i]) * 16'(WARP_STEP);
            if (w_cap > 16'(WARP_MAX)) w_cap = 16'(WARP_MAX);
            if (r_throttle_q) begin
                w_cap = w_cap >> 1;
                if (w_cap < 16'(WARP_MIN)) w_cap = 16'(WARP_MIN);
            end
            w_warp_d[i] = w_cap[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_q      <= '0;
            r_throttle_q <= 1'b0;
            r_req_vld_q  <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_ewma_q[i]    <= '0;
                r_up_q[i]      <= '0;
                r_dn_q[i]      <= '0;
                r_lvl_q[i]     <= '0;
                r_req_lvl_q[i] <= '0;
                r_warp_q[i]    <= 8'(WARP_BASE);
            end
        end else begin
            r_cnt_q      <= w_cnt_d;
            r_throttle_q <= w_throttle_d;
            r_req_vld_q  <= w_req_vld_d;
            for (int i = 0; i < NUM_CH; i++) begin
                r_ewma_q[i]    <= w_ewma_d[i];
                r_up_q[i]      <= w_up_d[i];
                r_dn_q[i]      <= w_dn_d[i];
                r_lvl_q[i]     <= w_lvl_d[i];
                r_req_lvl_q[i] <= w_req_lvl_d[i];
                r_warp_q[i]    <= w_warp_d[i];
            end
        end
    end

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_out
            assign dvfs_lvl[g*LVL_W +: LVL_W]     = r_lvl_q[g];
            assign dvfs_req_lvl[g*LVL_W +: LVL_W] = r_req_lvl_q[g];
            assign warp_cap[g*8 +: 8]             = r_warp_q[g];
        end
    endgenerate

    assign dvfs_req_vld = r_req_vld_q;
    assign throttle     = r_throttle_q;

endmodule
`default_nettype wire

// File: tb/tb_sm_selfopt_governor.sv
`default_nettype none
// ============================================================================
// Module   : tb_sm_selfopt_governor
// Brief    : Directed, self-checking bench for sm_selfopt_governor.
// Revision : 1.0
// ============================================================================
module tb_sm_selfopt_governor;

    logic        clk = 1'b0;
    logic        rst, enable;
    logic [63:0] perf_cnt;
    logic [3:0]  perf_vld;
    logic [15:0] power_budget;
    logic [3:0]  dvfs_req_vld;
    logic [7:0]  dvfs_req_lvl;
    logic [3:0]  dvfs_ack;
    logic [7:0]  dvfs_lvl;
    logic [31:0] warp_cap;
    logic        throttle;

    int total = 0;
    int bad   = 0;
    bit auto_ack = 1'b0;

    typedef struct {
        logic [3:0]  exp_vld;
        logic [7:0]  exp_req;
        logic [31:0] exp_warp;
    } frc_t;
    frc_t rows [6];

    always #5 clk = ~clk;

    sm_selfopt_governor dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .perf_cnt     (perf_cnt),
        .perf_vld     (perf_vld),
        .power_budget (power_budget),
        .dvfs_req_vld (dvfs_req_vld),
        .dvfs_req_lvl (dvfs_req_lvl),
        .dvfs_ack     (dvfs_ack),
        .dvfs_lvl     (dvfs_lvl),
        .warp_cap     (warp_cap),
        .throttle     (throttle)
    );

    task automatic step();
        @(posedge clk);
        #1;
        if (auto_ack) dvfs_ack = dvfs_req_vld;
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; enable = 1'b0; perf_vld = '0; perf_cnt = '0;
        dvfs_ack = '0; auto_ack = 1'b0; power_budget = 16'd1000;
        steps(3);
        rst = 1'b0;
    endtask

    task automatic pulse(input logic [3:0] mask, input logic [63:0] vals);
        perf_cnt = vals;
        perf_vld = mask;
        step();
        perf_vld = '0;
    endtask

    task automatic wait_vld(input int limit, output int n);
        n = 0;
        while (dvfs_req_vld == 4'b0 && n < limit) begin
            step();
            n++;
        end
    endtask

    initial begin
        int n;
        int errs;
        rows[0] = '{4'b0001, 8'hFE, 32'h20202020};
        rows[1] = '{4'b0010, 8'hFA, 32'h20202018};
        rows[2] = '{4'b0100, 8'hEA, 32'h20201818};
        rows[3] = '{4'b1000, 8'hAA, 32'h20181818};
        rows[4] = '{4'b0001, 8'hA9, 32'h18181818};
        rows[5] = '{4'b0010, 8'hA5, 32'h18181810};

        // Reset values, then ch0 ewma=2000 votes up; ch1 ewma=1003 sits on the band edge
        do_reset();
        chk("rst_vld", dvfs_req_vld, 4'h0);
        chk("rst_req_lvl", dvfs_req_lvl, 8'h00);
        chk("rst_lvl", dvfs_lvl, 8'h00);
        chk("rst_warp", warp_cap, 32'h10101010);
        chk("rst_throttle", throttle, 1'b0);
        pulse(4'b0011, {16'd0, 16'd0, 16'd16048, 16'd32000});
        enable = 1'b1;
        wait_vld(300, n);
        chk("up_latency", n, 192);
        chk("up_vld", dvfs_req_vld, 4'b0001);
        chk("up_req_lvl", dvfs_req_lvl, 8'h01);
        chk("up_lvl_before_ack", dvfs_lvl, 8'h00);
        step();
        chk("up_hold_vld", dvfs_req_vld, 4'b0001);
        step();
        dvfs_ack = 4'b0001;
        step();
        dvfs_ack = 4'b0000;
        chk("ack_vld_low", dvfs_req_vld, 4'b0000);
        chk("ack_lvl", dvfs_lvl, 8'h01);
        chk("ack_req_mirror", dvfs_req_lvl, 8'h01);
        chk("ack_warp_lag", warp_cap, 32'h10101010);
        step();
        chk("ack_warp", warp_cap, 32'h10101020);

        // Two up votes in the same tick, budget only covers one
        do_reset();
        power_budget = 16'd250;
        pulse(4'b0101, {16'd0, 16'd16064, 16'd0, 16'd16064});
        enable = 1'b1;
        wait_vld(300, n);
        chk("grant_latency", n, 192);
        chk("grant_only_ch0", dvfs_req_vld, 4'b0001);
        auto_ack = 1'b1;
        dvfs_ack = dvfs_req_vld;
        steps(64);
        chk("no_room_vld", dvfs_req_vld, 4'b0000);
        chk("no_room_lvl", dvfs_lvl, 8'h01);
        chk("at_budget_throttle", throttle, 1'b0);
        power_budget = 16'd300;
        steps(64);
        chk("ch2_grant_vld", dvfs_req_vld, 4'b0100);
        chk("ch2_grant_req", dvfs_req_lvl, 8'h11);

        // Ramp everything to level 3, then cut the budget to 500
        do_reset();
        power_budget = 16'hFFFF;
        pulse(4'b1111, {4{16'd16064}});
        enable   = 1'b1;
        auto_ack = 1'b1;
        n = 0;
        while (!(dvfs_lvl == 8'hFF && dvfs_req_vld == 4'b0) && n < 4000) begin
            step();
            n++;
        end
        chk("ramp_lvl", dvfs_lvl, 8'hFF);
        step();
        chk("ramp_warp", warp_cap, 32'h40404040);
        chk("ramp_throttle", throttle, 1'b0);
        pulse(4'b1111, {4{16'd928}});
        power_budget = 16'd500;
        for (int r = 0; r < 6; r++) begin
            wait_vld(70, n);
            if (r > 0) chk($sformatf("frc%0d_spacing", r), n, 63);
            chk($sformatf("frc%0d_vld", r), dvfs_req_vld, rows[r].exp_vld);
            chk($sformatf("frc%0d_req", r), dvfs_req_lvl, rows[r].exp_req);
            chk($sformatf("frc%0d_throttle", r), throttle, 1'b1);
            step();
            chk($sformatf("frc%0d_lvl", r), dvfs_lvl, rows[r].exp_req);
            chk($sformatf("frc%0d_warp", r), warp_cap, rows[r].exp_warp);
        end
        steps(62);
        chk("thr_still_set", throttle, 1'b1);
        chk("thr_warp", warp_cap, 32'h18181010);
        step();
        chk("thr_clear", throttle, 1'b0);
        chk("thr_clear_vld", dvfs_req_vld, 4'b0000);
        step();
        chk("thr_clear_warp", warp_cap, 32'h30302020);

        // Sequencer stalls the ack; a spurious ack on an idle channel
        do_reset();
        pulse(4'b0001, {48'd0, 16'd16064});
        enable = 1'b1;
        wait_vld(300, n);
        chk("stall_vld", dvfs_req_vld, 4'b0001);
        errs = 0;
        for (int k = 0; k < 500; k++) begin
            dvfs_ack = (k == 250) ? 4'b0010 : 4'b0000;
            step();
            if (dvfs_req_vld !== 4'b0001 || dvfs_req_lvl !== 8'h01 || dvfs_lvl !== 8'h00) errs++;
        end
        chk("stall_stable_cycles_bad", errs, 0);
        dvfs_ack = 4'b0001;
        step();
        dvfs_ack = 4'b0000;
        chk("stall_commit", dvfs_lvl, 8'h01);
        // ewma 999 is inside the band; 998 is below it
        pulse(4'b0001, {48'd0, 16'd912});
        errs = 0;
        for (int k = 0; k < 256; k++) begin
            step();
            if (dvfs_req_vld !== 4'b0000) errs++;
        end
        chk("band_edge_quiet_bad", errs, 0);
        pulse(4'b0001, {48'd0, 16'd976});
        wait_vld(200, n);
        chk("down_vld", dvfs_req_vld, 4'b0001);
        chk("down_req", dvfs_req_lvl, 8'h00);
        chk("down_lvl_held", dvfs_lvl, 8'h01);

        // Reset mid-handshake, then enable=0 blocks requests
        rst = 1'b1;
        step();
        chk("midrst_vld", dvfs_req_vld, 4'b0000);
        chk("midrst_lvl", dvfs_lvl, 8'h00);
        chk("midrst_req", dvfs_req_lvl, 8'h00);
        chk("midrst_warp", warp_cap, 32'h10101010);
        rst = 1'b0;
        enable = 1'b0;
        pulse(4'b0001, {48'd0, 16'd32000});
        errs = 0;
        for (int k = 0; k < 300; k++) begin
            step();
            if (dvfs_req_vld !== 4'b0000) errs++;
        end
        chk("disabled_quiet_bad", errs, 0);
        enable = 1'b1;
        wait_vld(300, n);
        chk("reenable_latency", n, 192);
        chk("reenable_req", dvfs_req_lvl, 8'h01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
